// File: rtl/tdm_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_if
// Brief    : TDM sample stream in, parallel frame and status out.
// Revision : 1.0
// ============================================================================
interface tdm_demux_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  logic [W-1:0]     din;
  logic             din_valid;
  logic             fsync;
  logic [NCH*W-1:0] ch_data;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, fsync,
    input  ch_data, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, fsync,
    output ch_data, frame_valid, locked, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Brief    : Locks to frame sync, steers samples into slots, publishes frames.
// Revision : 1.0
// ============================================================================
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  tdm_demux_if.slave    bus
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SW-1:0] C_LAST = SW'(NCH - 1);
  localparam logic [SW-1:0] C_ONE  = SW'(1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [NCH*W-1:0] shadow_q, shadow_d;
  logic [NCH*W-1:0] ch_data_q, ch_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      shadow_q      <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            shadow_d[W-1:0] = bus.din;
            slot_d          = C_ONE;
            state_d         = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.fsync) begin
            // Early sync restarts the frame; stale shadow slots get overwritten.
            sync_err_d      = (slot_q != '0);
            shadow_d[W-1:0] = bus.din;
            slot_d          = C_ONE;
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else if (slot_q == C_LAST) begin
            ch_data_d                    = shadow_q;
            ch_data_d[(NCH-1)*W +: W]    = bus.din;
            frame_valid_d                = 1'b1;
            slot_d                       = '0;
          end else begin
            shadow_d[int'(slot_q)*W +: W] = bus.din;
            slot_d                        = slot_q + C_ONE;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux
// Brief    : Directed self-checking bench for tdm_demux (NCH=4, W=8).
// Revision : 1.0
// ============================================================================
module tb_tdm_demux;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  tdm_demux_if #(.NCH(4), .W(8)) bus ();

  tdm_demux #(.NCH(4), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedge; after one posedge the registered outputs are
  // sampled at the following negedge.
  task automatic send(input logic [7:0] d, input logic fs);
    bus.din       = d;
    bus.din_valid = 1'b1;
    bus.fsync     = fs;
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.fsync     = 1'b0;
  endtask

  task automatic idle();
    bus.din_valid = 1'b0;
    bus.fsync     = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.ch_data !== 32'h0) begin n_fail++; $display("FAIL reset_ch_data got %h want 0", bus.ch_data); end
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got fv=%b se=%b lk=%b want 0 0 0", bus.frame_valid, bus.sync_err, bus.locked);
    end
  endtask

  task automatic test_contiguous();
    send(8'h11, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL contig_lock got %b want 1", bus.locked); end
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL contig_early_fv got %b want 0", bus.frame_valid); end
    send(8'h44, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'h44332211 || bus.locked !== 1'b1 || bus.sync_err !== 1'b0) begin
      n_fail++; $display("FAIL contig_frame got fv=%b ch=%h lk=%b se=%b want 1 44332211 1 0",
                         bus.frame_valid, bus.ch_data, bus.locked, bus.sync_err);
    end
    idle();
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL contig_pulse_width got %b want 0", bus.frame_valid); end
  endtask

  task automatic test_gaps();
    logic [7:0] v [4];
    int fv_cnt, se_cnt;
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
    fv_cnt = 0; se_cnt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(v[i], (i == 0));
      fv_cnt += int'(bus.frame_valid);
      se_cnt += int'(bus.sync_err);
      if (i < 3) begin
        for (int k = 0; k < 2; k++) begin
          idle();
          fv_cnt += int'(bus.frame_valid);
          se_cnt += int'(bus.sync_err);
        end
      end
    end
    idle();
    fv_cnt += int'(bus.frame_valid);
    n_checks++;
    if (fv_cnt != 1 || se_cnt != 0) begin n_fail++; $display("FAIL gaps_pulses got fv=%0d se=%0d want 1 0", fv_cnt, se_cnt); end
    n_checks++;
    if (bus.ch_data !== 32'h44332211) begin n_fail++; $display("FAIL gaps_ch_data got %h want 44332211", bus.ch_data); end
  endtask

  task automatic test_hunt_drop();
    int bad;
    bad = 0;
    do_reset();
    send(8'hAA, 1'b0);
    bad += int'(bus.locked | bus.frame_valid | bus.sync_err);
    send(8'hBB, 1'b0);
    bad += int'(bus.locked | bus.frame_valid | bus.sync_err);
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL hunt_drop got %0d flagged cycles want 0", bad); end
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'h04030201) begin
      n_fail++; $display("FAIL hunt_frame got fv=%b ch=%h want 1 04030201", bus.frame_valid, bus.ch_data);
    end
  endtask

  task automatic test_early_sync();
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    n_checks++;
    if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL early_pre_err got %b want 0", bus.sync_err); end
    send(8'h10, 1'b1);
    n_checks++;
    if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL early_err got se=%b fv=%b lk=%b want 1 0 1", bus.sync_err, bus.frame_valid, bus.locked);
    end
    send(8'h20, 1'b0);
    n_checks++;
    if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL early_err_width got %b want 0", bus.sync_err); end
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'h40302010) begin
      n_fail++; $display("FAIL early_frame got fv=%b ch=%h want 1 40302010", bus.frame_valid, bus.ch_data);
    end
  endtask

  task automatic test_missing_sync();
    send(8'h55, 1'b0);
    n_checks++;
    if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL missing_err got se=%b fv=%b want 1 0", bus.sync_err, bus.frame_valid);
    end
    idle();
    n_checks++;
    if (bus.locked !== 1'b0 || bus.ch_data !== 32'h40302010 || bus.sync_err !== 1'b0) begin
      n_fail++; $display("FAIL missing_hold got lk=%b ch=%h se=%b want 0 40302010 0", bus.locked, bus.ch_data, bus.sync_err);
    end
    send(8'hA1, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL missing_relock got %b want 1", bus.locked); end
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hD4, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'hD4C3B2A1) begin
      n_fail++; $display("FAIL missing_frame got fv=%b ch=%h want 1 d4c3b2a1", bus.frame_valid, bus.ch_data);
    end
  endtask

  task automatic test_back_to_back();
    send(8'h0A, 1'b1);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start got fv=%b se=%b want 0 0", bus.frame_valid, bus.sync_err);
    end
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    send(8'h0D, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'h0D0C0B0A) begin
      n_fail++; $display("FAIL b2b_frame1 got fv=%b ch=%h want 1 0d0c0b0a", bus.frame_valid, bus.ch_data);
    end
    send(8'hE1, 1'b1);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart got fv=%b se=%b want 0 0", bus.frame_valid, bus.sync_err);
    end
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    send(8'hE4, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'hE4E3E2E1) begin
      n_fail++; $display("FAIL b2b_frame2 got fv=%b ch=%h want 1 e4e3e2e1", bus.frame_valid, bus.ch_data);
    end
  endtask

  task automatic test_async_reset();
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ch_data !== 32'h0 || bus.locked !== 1'b0 || bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got ch=%h lk=%b fv=%b se=%b want 0 0 0 0",
                         bus.ch_data, bus.locked, bus.frame_valid, bus.sync_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h04, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.locked !== 1'b0 || bus.ch_data !== 32'h0) begin
      n_fail++; $display("FAIL async_tail got fv=%b lk=%b ch=%h want 0 0 0", bus.frame_valid, bus.locked, bus.ch_data);
    end
    idle();
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
      n_fail++; $display("FAIL async_after got fv=%b se=%b want 0 0", bus.frame_valid, bus.sync_err);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.fsync     = 1'b0;
    @(negedge clk);
    test_reset();
    test_contiguous();
    test_gaps();
    test_hunt_drop();
    test_early_sync();
    test_missing_sync();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
